sms_timing_ring_gen: RTL and testbench
======================================

Name: sms_timing_ring_gen

Overview:
- Parametrised, synthesizable successor to the free-running SMS oscillator card.
- Divides the system clock into an oscillator of programmable period and duty, and drives a one-hot timing ring of PHASES pulses that sequences a machine (memory) cycle.
- Adds run, halt-at-end-of-cycle and single-cycle modes, a cycle-start strobe and a cycle counter.
- Feeds the timing-trigger and memory-cycle logic cards.

Parameters:
- DIV, 10: system clocks per oscillator period; must be >= 2.
- HIGH, 2: clocks per period with osc high; must satisfy 1 <= HIGH <= DIV-1. Defaults give 20% duty.
- PHASES, 20: timing-ring length (oscillator periods per machine cycle); must be >= 2.
- CNT_W, 16: width of the completed-cycle counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run_req  in  1  one-clock request to start free-running cycles
- step_req  in  1  one-clock request to run exactly one machine cycle
- stop_req  in  1  one-clock request to halt at end of current cycle
- osc  out  1  free-running oscillator
- phase  out  PHASES  one-hot timing ring; all zero when idle
- cycle_start  out  1  one-clock strobe when phase[0] is entered
- running  out  1  high while the ring is active
- cycle_cnt  out  CNT_W  completed machine cycles, wraps modulo 2^CNT_W

Behaviour:
- Reset (synchronous, active-high):
  - div_cnt=0, osc=0, phase=0, cycle_start=0, running=0, cycle_cnt=0.
  - State IDLE; start_pend, stop_pend and single_mode cleared.
  - Applies mid-operation on the next edge, no cycle completion.
- Divider:
  - div_cnt counts 0..DIV-1 and wraps; it never stops outside reset.
  - osc is registered: osc=1 while div_cnt >= DIV-HIGH, else 0. Period is exactly DIV clocks with HIGH high.
  - tick = (div_cnt == DIV-1), combinational, i.e. the last clock of each period.
- Requests:
  - start_now = run_req | step_req | start_pend.
  - In IDLE, a run_req/step_req arriving off-tick sets start_pend and records single_mode = step_req & ~run_req. run_req wins if both are asserted.
  - If stop_req is asserted in the same clock as a start request, or while start_pend is set in IDLE, it clears start_pend.
  - run_req and step_req while not IDLE are ignored.
  - stop_req while running sets stop_pend, which holds until the end of the cycle.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on tick && start_now && !stop_req.
    - phase <= one-hot bit 0, running <= 1, cycle_start <= 1.
    - start_pend cleared.
    - single_mode <= (step_req & ~run_req) on a same-tick request, else the latched value.
  - In RUN on tick with phase[PHASES-1] clear: phase rotates left by one.
  - RUN on tick with phase[PHASES-1] set (end of cycle):
    - cycle_cnt increments, wrapping.
    - If stop_pend, or stop_req that clock, or single_mode: go to IDLE, phase <= 0, running <= 0, clear stop_pend and single_mode.
    - Otherwise phase <= bit 0 and cycle_start <= 1.
- cycle_start is high for exactly one clock, the first clock phase[0] is high; it is low at all other times.
- Phase width is exactly DIV clocks. phase changes only on the edge following tick, so phase edges align with osc falling edges.
- A stop never truncates a cycle: all PHASES phases always complete.
- Latency from run_req (off-tick) to phase[0] is the number of clocks until the next tick plus 1 (max DIV).

Decomposition:
- Shared package sms_timing_pkg: state enum (IDLE, RUN) and the parameter legality checks (DIV>=2, 1<=HIGH<DIV, PHASES>=2) as elaboration-time assertions.
- One natural sub-module: sms_osc_div (div_cnt, osc, tick), parametrised by DIV and HIGH. It is reusable as the generic oscillator card.
- The ring, FSM and counter stay in the top module.

Test Plan:
- Reset then free-run, defaults: osc low 8 clocks, high 2, period 10; phase=0; running=0 for 200 clocks.
- run_req pulse at clock 3 after reset: phase[0] rises at clock 10; cycle_start is one pulse; each phase lasts 10 clocks. After 200 clocks phase[0] re-enters with cycle_start, and cycle_cnt=1.
- step_req pulse: exactly 20 phases (200 clocks), cycle_cnt=1, then running=0 and phase=0. A run_req during that cycle has no effect.
- stop_req during phase[7] of the third cycle: ring completes phase[19], cycle_cnt=3, IDLE. A later run_req restarts at phase[0].
- stop_req in the same clock as a tick-aligned run_req in IDLE: no start, start_pend=0. A stop_req in the last clock of phase[19] halts at that cycle boundary.
- Reset asserted mid-phase[12]: next edge gives all outputs at reset values. Parameter sweep (DIV=2/HIGH=1, DIV=7/HIGH=6, PHASES=2) checks one-hot invariants and the cycle_cnt wrap with CNT_W=2 (3 -> 0).

Source files
------------

// File: rtl/sms_timing_pkg.sv
// Shared types and parameter legality check for the SMS timing ring generator.
//   state_t    : ring sequencer state (IDLE, RUN)
//   params_ok  : true when DIV/HIGH/PHASES form a legal configuration
package sms_timing_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // DIV >= 2, 1 <= HIGH <= DIV-1, PHASES >= 2
  function automatic bit params_ok(input int div, input int high, input int phases);
    return (div >= 2) && (high >= 1) && (high <= div - 1) && (phases >= 2);
  endfunction

endpackage

// File: rtl/sms_osc_div.sv
// Programmable-period oscillator: divides i_clk by DIV, osc high for the
// last HIGH clocks of every period. Free-running outside reset.
//   i_clk   : system clock
//   i_reset : synchronous active-high reset
//   o_osc   : registered oscillator output
//   o_tick  : high on the last clock of each period (combinational)
module sms_osc_div
  import sms_timing_pkg::*;
#(
  parameter int DIV  = 10,
  parameter int HIGH = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_osc,
  output logic o_tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] HI_BEG = CW'(DIV - HIGH);

  generate
    if (!params_ok(DIV, HIGH, 2)) begin : g_bad_params
      $error("sms_osc_div: illegal DIV/HIGH");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic          r_osc;
  logic [CW-1:0] w_next;

  assign w_next = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
  assign o_tick = (r_cnt == LAST);
  assign o_osc  = r_osc;

  // osc is computed from the next count so it stays aligned with r_cnt.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_osc <= 1'b0;
    end else begin
      r_cnt <= w_next;
      r_osc <= (w_next >= HI_BEG);
    end
  end

endmodule

// File: rtl/sms_timing_ring_gen.sv
// SMS timing ring generator: oscillator plus a one-hot ring of PHASES
// pulses sequencing a machine cycle, with run / single-step / halt-at-end.
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_run_req       : start free-running cycles (one clock)
//   i_step_req      : run exactly one machine cycle (one clock)
//   i_stop_req      : halt at end of the current cycle (one clock)
//   o_osc           : free-running oscillator
//   o_phase         : one-hot ring, zero when idle
//   o_cycle_start   : one-clock strobe entering phase[0]
//   o_running       : ring active
//   o_cycle_cnt     : completed machine cycles (wraps)
module sms_timing_ring_gen
  import sms_timing_pkg::*;
#(
  parameter int DIV    = 10,
  parameter int HIGH   = 2,
  parameter int PHASES = 20,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run_req,
  input  logic              i_step_req,
  input  logic              i_stop_req,
  output logic              o_osc,
  output logic [PHASES-1:0] o_phase,
  output logic              o_cycle_start,
  output logic              o_running,
  output logic [CNT_W-1:0]  o_cycle_cnt
);

  generate
    if (!params_ok(DIV, HIGH, PHASES)) begin : g_bad_params
      $error("sms_timing_ring_gen: illegal DIV/HIGH/PHASES");
    end
  endgenerate

  localparam logic [PHASES-1:0] PH0 = PHASES'(1);

  logic w_tick;
  logic w_req;
  logic w_start_now;

  state_t            r_state;
  logic [PHASES-1:0] r_phase;
  logic              r_cycle_start;
  logic              r_running;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_start_pend;
  logic              r_stop_pend;
  logic              r_single;

  sms_osc_div #(.DIV(DIV), .HIGH(HIGH)) u_osc (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_osc   (o_osc),
    .o_tick  (w_tick)
  );

  assign w_req       = i_run_req | i_step_req;
  assign w_start_now = w_req | r_start_pend;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_phase       <= '0;
      r_cycle_start <= 1'b0;
      r_running     <= 1'b0;
      r_cnt         <= '0;
      r_start_pend  <= 1'b0;
      r_stop_pend   <= 1'b0;
      r_single      <= 1'b0;
    end else begin
      r_cycle_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_tick && w_start_now && !i_stop_req) begin
            r_state       <= ST_RUN;
            r_phase       <= PH0;
            r_running     <= 1'b1;
            r_cycle_start <= 1'b1;
            r_start_pend  <= 1'b0;
            if (w_req) r_single <= i_step_req & ~i_run_req;
          end else if (i_stop_req) begin
            // stop cancels a pending or simultaneous start
            r_start_pend <= 1'b0;
          end else if (w_req) begin
            r_start_pend <= 1'b1;
            r_single     <= i_step_req & ~i_run_req;
          end
        end
        ST_RUN: begin
          if (i_stop_req) r_stop_pend <= 1'b1;
          if (w_tick) begin
            if (r_phase[PHASES-1]) begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_stop_pend || i_stop_req || r_single) begin
                r_state     <= ST_IDLE;
                r_phase     <= '0;
                r_running   <= 1'b0;
                r_stop_pend <= 1'b0;
                r_single    <= 1'b0;
              end else begin
                r_phase       <= PH0;
                r_cycle_start <= 1'b1;
              end
            end else begin
              r_phase <= {r_phase[PHASES-2:0], 1'b0};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_phase       = r_phase;
  assign o_cycle_start = r_cycle_start;
  assign o_running     = r_running;
  assign o_cycle_cnt   = r_cnt;

endmodule

// File: tb/tb_sms_timing_ring_gen.sv
// Scoreboard bench: one stimulus stream drives three configurations of the
// ring generator; a behavioural model per configuration pushes the expected
// post-edge outputs, a monitor pops and compares after every edge.
module tb_sms_timing_ring_gen;

  localparam int NC = 3;
  localparam int DV [NC] = '{10, 2, 7};
  localparam int HI [NC] = '{2, 1, 6};
  localparam int PH [NC] = '{20, 2, 3};
  localparam int CW [NC] = '{16, 2, 2};

  typedef struct packed {
    logic        osc;
    logic [19:0] ph;
    logic        cs;
    logic        run;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    int t;      // divider count (clocks into the current period)
    bit act;    // ring active
    int idx;    // active phase index
    int cnt;    // completed cycles
    bit pend, single, stp, cs;
  } mst_t;

  logic clk = 1'b0;
  logic i_reset = 1'b1, i_run_req = 1'b0, i_step_req = 1'b0, i_stop_req = 1'b0;

  logic        osc0, osc1, osc2, cs0, cs1, cs2, run0, run1, run2;
  logic [19:0] ph0;
  logic [1:0]  ph1, cnt1, cnt2;
  logic [2:0]  ph2;
  logic [15:0] cnt0;

  exp_t act_v [NC];
  exp_t q [NC][$];
  mst_t m [NC];
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  sms_timing_ring_gen #(.DIV(10), .HIGH(2), .PHASES(20), .CNT_W(16)) dut0 (
    .i_clk(clk), .i_reset(i_reset), .i_run_req(i_run_req), .i_step_req(i_step_req),
    .i_stop_req(i_stop_req), .o_osc(osc0), .o_phase(ph0), .o_cycle_start(cs0),
    .o_running(run0), .o_cycle_cnt(cnt0));
  sms_timing_ring_gen #(.DIV(2), .HIGH(1), .PHASES(2), .CNT_W(2)) dut1 (
    .i_clk(clk), .i_reset(i_reset), .i_run_req(i_run_req), .i_step_req(i_step_req),
    .i_stop_req(i_stop_req), .o_osc(osc1), .o_phase(ph1), .o_cycle_start(cs1),
    .o_running(run1), .o_cycle_cnt(cnt1));
  sms_timing_ring_gen #(.DIV(7), .HIGH(6), .PHASES(3), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_reset(i_reset), .i_run_req(i_run_req), .i_step_req(i_step_req),
    .i_stop_req(i_stop_req), .o_osc(osc2), .o_phase(ph2), .o_cycle_start(cs2),
    .o_running(run2), .o_cycle_cnt(cnt2));

  assign act_v[0] = {osc0, ph0, cs0, run0, cnt0};
  assign act_v[1] = {osc1, 18'b0, ph1, cs1, run1, 14'b0, cnt1};
  assign act_v[2] = {osc2, 17'b0, ph2, cs2, run2, 14'b0, cnt2};

  function automatic mst_t reset_state();
    mst_t s;
    s.t = 0; s.act = 0; s.idx = 0; s.cnt = 0;
    s.pend = 0; s.single = 0; s.stp = 0; s.cs = 0;
    return s;
  endfunction

  // Reference: advance configuration i across one clock edge with the given
  // inputs and push the outputs the DUT must show after that edge.
  task automatic mstep(input int i, input bit rst, input bit run, input bit step, input bit stop);
    mst_t s;
    bit   tick;
    exp_t e;
    s = m[i];
    if (rst) s = reset_state();
    else begin
      tick = (s.t == DV[i] - 1);
      s.t  = (s.t + 1) % DV[i];
      s.cs = 0;
      if (!s.act) begin
        if (tick && (run || step || s.pend) && !stop) begin
          s.act = 1; s.idx = 0; s.cs = 1; s.pend = 0;
          if (run || step) s.single = step && !run;
        end else if (stop) s.pend = 0;
        else if (run || step) begin
          s.pend = 1; s.single = step && !run;
        end
      end else begin
        if (stop) s.stp = 1;
        if (tick) begin
          if (s.idx == PH[i] - 1) begin
            s.cnt = (s.cnt + 1) % (1 << CW[i]);
            if (s.stp || s.single) begin
              s.act = 0; s.stp = 0; s.single = 0;
            end else begin
              s.idx = 0; s.cs = 1;
            end
          end else s.idx++;
        end
      end
    end
    m[i]  = s;
    e.osc = (s.t >= DV[i] - HI[i]);
    e.ph  = s.act ? (20'd1 << s.idx) : 20'd0;
    e.cs  = s.cs;
    e.run = s.act;
    e.cnt = 16'(s.cnt);
    q[i].push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit run, input bit step, input bit stop);
    @(negedge clk);
    i_reset = rst; i_run_req = run; i_step_req = step; i_stop_req = stop;
    for (int i = 0; i < NC; i++) mstep(i, rst, run, step, stop);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
  endtask

  // Idle until config 0 reaches (phase idx, div count) with the ring in the
  // given activity state; bounded.
  task automatic wait_pos(input bit act, input int idx, input int t);
    int n = 0;
    while (!(m[0].act == act && (!act || m[0].idx == idx) && m[0].t == t) && n < 1000) begin
      cyc(0, 0, 0, 0); n++;
    end
    if (n >= 1000) begin
      errors++;
      $display("FAIL wait_pos: position act=%0d idx=%0d t=%0d never reached", act, idx, t);
    end
    checks++;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NC; i++) begin
        if (q[i].size() > 0) begin
          e = q[i].pop_front();
          checks++;
          if (act_v[i] !== e) begin
            errors++;
            $display("FAIL cfg%0d outputs @%0t: got osc=%b ph=%h cs=%b run=%b cnt=%0d, want osc=%b ph=%h cs=%b run=%b cnt=%0d",
                     i, $time, act_v[i].osc, act_v[i].ph, act_v[i].cs, act_v[i].run, act_v[i].cnt,
                     e.osc, e.ph, e.cs, e.run, e.cnt);
          end
          checks++;
          if (!$onehot0(act_v[i].ph)) begin
            errors++;
            $display("FAIL cfg%0d onehot @%0t: got ph=%h, want at most one bit", i, $time, act_v[i].ph);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int r;
    for (int i = 0; i < NC; i++) m[i] = reset_state();
    // reset, then free-run with no requests
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    idle(200);
    // run_req at clock 3 after reset, two full cycles
    cyc(1, 0, 0, 0);
    idle(3); cyc(0, 1, 0, 0);
    idle(420);
    // single step with a run_req inside the cycle
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0); idle(50); cyc(0, 1, 0, 0); idle(200);
    // stop during phase[7] of the third cycle, then restart
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    idle(10 + 400 + 75);
    cyc(0, 0, 0, 1);
    idle(200);
    cyc(0, 1, 0, 0); idle(60);
    // tick-aligned run with simultaneous stop: no start
    cyc(1, 0, 0, 0);
    wait_pos(0, 0, 9);
    cyc(0, 1, 0, 1); idle(30);
    // stop in the last clock of phase[19]
    cyc(0, 1, 0, 0);
    wait_pos(1, 19, 9);
    cyc(0, 0, 0, 1); idle(30);
    // reset mid-phase[12]
    cyc(0, 1, 0, 0);
    wait_pos(1, 12, 4);
    cyc(1, 0, 0, 0); idle(20);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      cyc($urandom_range(0, 999) == 0, r < 2, r == 2 || r == 3, r == 4 || r == 5);
    end
    @(posedge clk); #2;
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (q[i].size() != 0) begin
        errors++;
        $display("FAIL cfg%0d drain: got %0d pending entries, want 0", i, q[i].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
